// File: rtl/seq_multiplier_param.sv
// Sequential shift-add multiplier retiring STEP multiplier bits per cycle, with
// signed/unsigned operands, a fixed-latency sign-fix stage and a ready/valid result.
module seq_multiplier_param #(
    parameter  int WIDTH = 8,
    parameter  int STEP  = 1,
    localparam int N     = WIDTH / STEP,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 ri,
    output logic [2*WIDTH-1:0]   product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           STATE,
    output logic [CNT_W-1:0]     cnt
);

    generate
        if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("seq_multiplier_param: WIDTH must be even and >= 4");
        end
        if (!(STEP == 1 || STEP == 2 || STEP == 4) || (WIDTH % STEP) != 0) begin : g_bad_step
            $error("seq_multiplier_param: STEP must be 1, 2 or 4 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COMPUTE = 2'b01,
        S_FIX     = 2'b10,
        S_DONE    = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_mcand_sh;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_neg;
    logic                 r_out_valid;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [2*WIDTH-1:0]   w_partial;
    logic                 w_last;

    // Magnitudes are taken as WIDTH-bit unsigned, so the most negative value maps cleanly.
    assign w_a_neg = signed_mode & a[WIDTH-1];
    assign w_b_neg = signed_mode & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~a + WIDTH'(1)) : a;
    assign w_b_mag = w_b_neg ? (~b + WIDTH'(1)) : b;
    assign w_last  = (r_cnt == LAST_CNT);

    always_comb begin
        w_partial = '0;
        for (int i = 0; i < STEP; i++) begin
            if (r_mplier[i]) begin
                w_partial = w_partial + (r_mcand_sh << i);
            end
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mcand_sh  <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_product   <= '0;
            r_neg       <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand_sh <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier   <= w_b_mag;
                        r_neg      <= w_a_neg ^ w_b_neg;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_state    <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    r_acc      <= r_acc + w_partial;
                    r_mcand_sh <= r_mcand_sh << STEP;
                    r_mplier   <= r_mplier >> STEP;
                    r_cnt      <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_product   <= r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ri        = (r_state == S_IDLE);
    assign product   = r_product;
    assign out_valid = r_out_valid;
    assign STATE     = r_state;
    assign cnt       = r_cnt;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Directed and table-driven checks of seq_multiplier_param for (8,1), (8,2) and
// (16,4), plus a randomized signed sweep of the (16,4) instance against a model.
module tb_seq_multiplier_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // WIDTH=8, STEP=1
    logic        iv8, sm8, ri8, ov8, ordy8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;
    logic [1:0]  st8;
    logic [3:0]  cnt8;

    // WIDTH=8, STEP=2
    logic        iv82, sm82, ri82, ov82, ordy82;
    logic [7:0]  a82, b82;
    logic [15:0] prod82;
    logic [1:0]  st82;
    logic [2:0]  cnt82;

    // WIDTH=16, STEP=4
    logic        iv16, sm16, ri16, ov16, ordy16;
    logic [15:0] a16, b16;
    logic [31:0] prod16;
    logic [1:0]  st16;
    logic [2:0]  cnt16;

    seq_multiplier_param #(.WIDTH(8), .STEP(1)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .signed_mode(sm8),
        .ri(ri8), .product(prod8), .out_valid(ov8), .out_ready(ordy8),
        .STATE(st8), .cnt(cnt8)
    );

    seq_multiplier_param #(.WIDTH(8), .STEP(2)) u_dut82 (
        .clk(clk), .rst(rst), .in_valid(iv82), .a(a82), .b(b82), .signed_mode(sm82),
        .ri(ri82), .product(prod82), .out_valid(ov82), .out_ready(ordy82),
        .STATE(st82), .cnt(cnt82)
    );

    seq_multiplier_param #(.WIDTH(16), .STEP(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .a(a16), .b(b16), .signed_mode(sm16),
        .ri(ri16), .product(prod16), .out_valid(ov16), .out_ready(ordy16),
        .STATE(st16), .cnt(cnt16)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] exp;
    } vec8_t;

    vec8_t vecs[12];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic op8(input logic [7:0] va, input logic [7:0] vb, input logic vsm,
                       input logic [15:0] vexp, input logic chk_idle);
        int lat;
        @(negedge clk);
        a8 = va; b8 = vb; sm8 = vsm; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        check("w8_accept_state", st8, 2'b01);
        lat = 0;
        while (!ov8 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("w8_latency", lat, 9);
        check("w8_product", prod8, vexp);
        if (chk_idle) begin
            @(negedge clk);
            check("w8_idle_state", st8, 2'b00);
            check("w8_idle_ri", ri8, 1'b1);
        end
    endtask

    task automatic op82(input logic [7:0] va, input logic [7:0] vb, input logic vsm,
                        input logic [15:0] vexp);
        int lat;
        @(negedge clk);
        a82 = va; b82 = vb; sm82 = vsm; iv82 = 1'b1;
        @(negedge clk);
        iv82 = 1'b0;
        lat = 0;
        while (!ov82 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("w8s2_latency", lat, 5);
        check("w8s2_product", prod82, vexp);
    endtask

    task automatic op16(input logic [15:0] va, input logic [15:0] vb, input logic vsm,
                        input logic [31:0] vexp);
        int lat;
        @(negedge clk);
        a16 = va; b16 = vb; sm16 = vsm; iv16 = 1'b1;
        @(negedge clk);
        iv16 = 1'b0;
        lat = 0;
        while (!ov16 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("w16_latency", lat, 5);
        check("w16_product", prod16, vexp);
    endtask

    initial begin
        int lat;
        int g;
        logic seen_ov;
        logic signed [15:0] sa, sb;
        logic signed [31:0] sp;

        vecs[0]  = '{8'd255, 8'd255, 1'b0, 16'hFE01};
        vecs[1]  = '{8'h80,  8'h80,  1'b1, 16'h4000};
        vecs[2]  = '{8'hFD,  8'd5,   1'b1, 16'hFFF1};
        vecs[3]  = '{8'h80,  8'h80,  1'b0, 16'h4000};
        vecs[4]  = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
        vecs[5]  = '{8'hFF,  8'h01,  1'b0, 16'h00FF};
        vecs[6]  = '{8'h7F,  8'h80,  1'b1, 16'hC080};
        vecs[7]  = '{8'h00,  8'h80,  1'b1, 16'h0000};
        vecs[8]  = '{8'd12,  8'd13,  1'b0, 16'h009C};
        vecs[9]  = '{8'hFF,  8'h01,  1'b1, 16'hFFFF};
        vecs[10] = '{8'h80,  8'h01,  1'b1, 16'hFF80};
        vecs[11] = '{8'hFD,  8'd5,   1'b0, 16'h04F1};

        rst = 1'b1;
        iv8 = 0; a8 = 0; b8 = 0; sm8 = 0; ordy8 = 1;
        iv82 = 0; a82 = 0; b82 = 0; sm82 = 0; ordy82 = 1;
        iv16 = 0; a16 = 0; b16 = 0; sm16 = 0; ordy16 = 1;
        repeat (3) @(negedge clk);
        check("rst_state", st8, 2'b00);
        check("rst_cnt", cnt8, 4'd0);
        check("rst_product", prod8, 16'h0000);
        check("rst_out_valid", ov8, 1'b0);
        check("rst_ri", ri8, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, 1'b1);
        end

        // Backpressure: DONE must hold while new operands churn on the inputs.
        ordy8 = 1'b0;
        op8(8'd7, 8'd9, 1'b0, 16'd63, 1'b0);
        for (int k = 0; k < 5; k++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = k[0]; iv8 = 1'b1;
            @(negedge clk);
            check("bp_product", prod8, 16'd63);
            check("bp_cnt", cnt8, 4'd8);
            check("bp_out_valid", ov8, 1'b1);
            check("bp_ri", ri8, 1'b0);
            check("bp_state", st8, 2'b11);
        end
        a8 = 8'd10; b8 = 8'd10; sm8 = 1'b0; iv8 = 1'b1; ordy8 = 1'b1;
        @(negedge clk);
        check("bp_release_state", st8, 2'b00);
        check("bp_idle_product_held", prod8, 16'd63);
        check("bp_idle_out_valid", ov8, 1'b0);
        @(negedge clk);
        check("bp_new_accept", st8, 2'b01);
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("bp_new_latency", lat, 9);
        check("bp_new_product", prod8, 16'd100);

        // Reset in the middle of COMPUTE.
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd77; sm8 = 1'b0; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        g = 0;
        while (cnt8 != 4'd3 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("mid_state", st8, 2'b01);
        check("mid_cnt", cnt8, 4'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_state", st8, 2'b00);
        check("mid_rst_cnt", cnt8, 4'd0);
        check("mid_rst_out_valid", ov8, 1'b0);
        check("mid_rst_product", prod8, 16'h0000);
        check("mid_rst_ri", ri8, 1'b1);
        seen_ov = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ov8) seen_ov = 1'b1;
        end
        check("mid_rst_no_out_valid", seen_ov, 1'b0);

        // STEP=2 instance.
        op82(8'd200, 8'd3, 1'b0, 16'd600);
        op82(8'd255, 8'd255, 1'b0, 16'hFE01);
        op82(8'hFD, 8'd5, 1'b1, 16'hFFF1);
        op82(8'h80, 8'h80, 1'b1, 16'h4000);

        // WIDTH=16, STEP=4: corners then a randomized signed sweep.
        op16(16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        op16(16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000);
        for (int i = 0; i < 1000; i++) begin
            sa = 16'($urandom);
            sb = 16'($urandom);
            sp = sa * sb;
            op16(sa, sb, 1'b1, sp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_multiplier_param.md
SEQ_MULTIPLIER_PARAM -- requirements
Module: seq_multiplier_param

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; legal values are even and at least 4.
REQ-002 Parameter: STEP, 1, multiplier bits retired per COMPUTE cycle; legal values are 1, 2 or 4, and STEP shall divide WIDTH.
REQ-003 Derived constants: N = WIDTH/STEP; CNT_W = $clog2(N+1).
REQ-004 Reset is synchronous and active-high; one clock.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  operand pair on a/b is valid.
REQ-008 a  in  WIDTH  multiplicand.
REQ-009 b  in  WIDTH  multiplier.
REQ-010 signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
REQ-011 ri  out  1  read indicator (input ready); 1 only in IDLE.
REQ-012 product  out  2*WIDTH  result; meaningful while out_valid=1.
REQ-013 out_valid  out  1  product is valid.
REQ-014 out_ready  in  1  consumer accepts product.
REQ-015 STATE  out  2  current FSM state.
REQ-016 cnt  out  CNT_W  COMPUTE cycles elapsed for the current operation.

Function
REQ-017 FSM encoding: 2'b00 IDLE, 2'b01 COMPUTE, 2'b10 FIX, 2'b11 DONE.
REQ-018 ri is 1 iff STATE==IDLE, driven combinationally from the state register.
REQ-019 Accept: at an edge with STATE==IDLE and in_valid=1, latch a, b and signed_mode; clear cnt to 0; go to COMPUTE.
REQ-020 Signed latch: if signed_mode=1, latch |a| and |b| as WIDTH-bit unsigned magnitudes (-2^(WIDTH-1) maps to 2^(WIDTH-1)), and latch neg = a[WIDTH-1]^b[WIDTH-1].
REQ-021 Unsigned latch: if signed_mode=0, latch a and b unchanged, with neg=0.
REQ-022 COMPUTE: each edge adds (multiplicand * next STEP multiplier bits, LSB first) into a 2*WIDTH accumulator, shifted appropriately, and increments cnt.
REQ-023 COMPUTE exit: after N COMPUTE edges (cnt==N), go to FIX.
REQ-024 FIX lasts exactly one cycle in both modes: product <= neg ? -acc : acc (2*WIDTH-bit two's complement); go to DONE. FIX is never skipped, so latency is constant.
REQ-025 Latency: out_valid rises on the edge N+1 edges after the accept edge (N=8: 9 cycles).
REQ-026 DONE: out_valid=1; product and cnt hold stable.
REQ-027 DONE exit: at an edge with out_ready=1, go to IDLE and clear out_valid. While out_ready=0, remain in DONE indefinitely.
REQ-028 in_valid is ignored in every state except IDLE, and the operand inputs are not re-sampled.
REQ-029 Throughput: at most one operation per N+2 cycles.
REQ-030 Arithmetic: results shall be exact; no truncation or saturation in either mode.
REQ-031 product is updated only in FIX; it retains its last value in IDLE.

Reset
REQ-032 When rst=1 at an edge, regardless of state or in_valid: STATE=IDLE, cnt=0, product=0, out_valid=0, accumulator=0, neg=0.
REQ-033 Consequently ri=1 after any reset edge.
REQ-034 rst has priority over accept and over the out_ready handshake.
REQ-035 Reset in COMPUTE, FIX or DONE abandons the operation; no out_valid pulse follows.

Verification
REQ-036 WIDTH=8, STEP=1, unsigned: a=255, b=255, out_ready=1 -> out_valid 9 cycles after accept, product=16'hFE01, then STATE=00 and ri=1 one cycle later.
REQ-037 Signed corner: a=8'h80, b=8'h80, signed_mode=1 -> product=16'h4000. Separately, a=-3, b=5 -> product=16'hFFF1.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands toggling -> product, cnt=8 and out_valid=1 stable, ri=0; release -> IDLE, then the new pair is accepted.
REQ-039 Reset mid-operation: rst=1 while STATE=01 and cnt=3 -> next cycle STATE=00, cnt=0, out_valid=0, product=0, ri=1, and no later out_valid.
REQ-040 WIDTH=8, STEP=2: a=200, b=3 unsigned -> out_valid 5 cycles after accept, product=16'd600.
REQ-041 WIDTH=16, STEP=4, signed, random 1000 pairs vs reference model -> all exact, latency=5 each.
